// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver/transmitter state encoding, the default
// oversample ratio and the parity helper both ends of the link use.
package uart_pkg;

  // Receiver FSM states (3-bit encoding).
  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4,
    ST_BREAK  = 3'd5
  } uart_state_e;

  // Ticks per bit period produced by the shared baud generator.
  localparam int unsigned OVERSAMPLE_DEFAULT = 16;

  // Widest data word the parity helper accepts.
  localparam int unsigned PARITY_MAX_BITS = 32;

  // Parity over the low n_bits of data. even=1 returns ^data (even parity),
  // even=0 returns ~^data (odd parity).
  function automatic logic parity_bit(
    input logic [PARITY_MAX_BITS-1:0] data,
    input int unsigned                n_bits,
    input logic                       even
  );
    logic acc;
    acc = 1'b0;
    for (int unsigned i = 0; i < PARITY_MAX_BITS; i++) begin
      if (i < n_bits) begin
        acc = acc ^ data[i];
      end
    end
    return even ? acc : ~acc;
  endfunction

endpackage

// File: rtl/uart_sync2.sv
// Two-flop synchronizer for a single asynchronous input. The reset value is a
// parameter so idle-high lines (like a UART rx) do not glitch low out of reset.
module uart_sync2 #(
  parameter logic RESET_VALUE = 1'b1
) (
  input  logic i_clock,
  input  logic i_reset,
  input  logic i_async,
  output logic o_sync
);

  logic meta_q, meta_d;
  logic sync_q, sync_d;

  // Next-value logic: the first stage captures the raw input, the second
  // stage re-times the (possibly metastable) first stage.
  always_comb begin
    meta_d = i_async;
    sync_d = meta_q;
  end

  // Synchronizer flops with synchronous reset to the line's idle level.
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      meta_q <= RESET_VALUE;
      sync_q <= RESET_VALUE;
    end else begin
      meta_q <= meta_d;
      sync_q <= sync_d;
    end
  end

  assign o_sync = sync_q;

endmodule

// File: rtl/uart_receiver.sv
// UART receiver: oversampled start detection, centre-of-bit sampling of
// N_DATA LSB-first data bits, optional parity and M_STOP stop bits.
// Completed frames (good or bad) produce a one-cycle o_rx_done pulse with the
// word and error flags held until the next frame completes.
module uart_receiver
  import uart_pkg::*;
#(
  parameter int unsigned NB_DATA         = 8,
  parameter int unsigned N_DATA          = 8,
  parameter bit          PARITY_CHECK    = 1'b1,
  parameter bit          EVEN_ODD_PARITY = 1'b1,
  parameter int unsigned M_STOP          = 1,
  parameter int unsigned OVERSAMPLE      = OVERSAMPLE_DEFAULT
) (
  input  logic               i_clock,
  input  logic               i_reset,
  input  logic               i_tick,
  input  logic               i_rx,
  output logic [NB_DATA-1:0] o_data,
  output logic               o_rx_done,
  output logic               o_parity_err,
  output logic               o_frame_err
);

  // Counter widths and the tick/bit counts that trigger a sample.
  localparam int unsigned TCW     = $clog2(OVERSAMPLE);
  localparam int unsigned BIT_MAX = (N_DATA > M_STOP) ? N_DATA : M_STOP;
  localparam int unsigned BCW     = $clog2(BIT_MAX + 1);

  localparam logic [TCW-1:0] TICK_MID  = TCW'(OVERSAMPLE / 2 - 1);
  localparam logic [TCW-1:0] TICK_LAST = TCW'(OVERSAMPLE - 1);
  localparam logic [BCW-1:0] DATA_LAST = BCW'(N_DATA - 1);
  localparam logic [BCW-1:0] STOP_LAST = BCW'(M_STOP - 1);

  // Synchronized serial line; every decision below uses this, never i_rx.
  logic rx_s;

  uart_sync2 #(
    .RESET_VALUE (1'b1)
  ) u_rx_sync (
    .i_clock (i_clock),
    .i_reset (i_reset),
    .i_async (i_rx),
    .o_sync  (rx_s)
  );

  // FSM state and sampling counters.
  uart_state_e       state_q, state_d;
  logic [TCW-1:0]    tick_cnt_q, tick_cnt_d;
  logic [BCW-1:0]    bit_cnt_q, bit_cnt_d;

  // Frame accumulation: data shift register and per-frame error flags.
  logic [N_DATA-1:0] shift_q, shift_d;
  logic              par_mis_q, par_mis_d;
  logic              stop_low_q, stop_low_d;

  // Output registers, loaded only when a frame completes.
  logic [NB_DATA-1:0] data_q, data_d;
  logic               rx_done_q, rx_done_d;
  logic               parity_err_q, parity_err_d;
  logic               frame_err_q, frame_err_d;

  // Helper terms for the sampling points.
  logic              centre_tick;
  logic              parity_expected;
  logic              stop_low_now;

  assign centre_tick     = (tick_cnt_q == TICK_LAST);
  assign parity_expected = parity_bit(PARITY_MAX_BITS'(shift_q), N_DATA, EVEN_ODD_PARITY);
  assign stop_low_now    = stop_low_q | ~rx_s;

  // Next-state and datapath logic; everything advances only on i_tick, while
  // the done pulse defaults low every cycle so it lasts exactly one clock.
  always_comb begin
    state_d      = state_q;
    tick_cnt_d   = tick_cnt_q;
    bit_cnt_d    = bit_cnt_q;
    shift_d      = shift_q;
    par_mis_d    = par_mis_q;
    stop_low_d   = stop_low_q;
    data_d       = data_q;
    parity_err_d = parity_err_q;
    frame_err_d  = frame_err_q;
    rx_done_d    = 1'b0;

    if (i_tick) begin
      case (state_q)
        ST_IDLE: begin
          // A low line on a tick is a candidate start edge.
          if (!rx_s) begin
            state_d    = ST_START;
            tick_cnt_d = '0;
          end
        end

        ST_START: begin
          // Re-check the line half a bit later to reject glitches.
          if (tick_cnt_q == TICK_MID) begin
            tick_cnt_d = '0;
            if (rx_s) begin
              state_d = ST_IDLE;
            end else begin
              state_d    = ST_DATA;
              bit_cnt_d  = '0;
              par_mis_d  = 1'b0;
              stop_low_d = 1'b0;
            end
          end else begin
            tick_cnt_d = tick_cnt_q + TCW'(1);
          end
        end

        ST_DATA: begin
          if (centre_tick) begin
            tick_cnt_d = '0;
            // LSB arrives first, so shift in from the top.
            shift_d              = shift_q >> 1;
            shift_d[N_DATA-1]    = rx_s;
            if (bit_cnt_q == DATA_LAST) begin
              bit_cnt_d = '0;
              state_d   = PARITY_CHECK ? ST_PARITY : ST_STOP;
            end else begin
              bit_cnt_d = bit_cnt_q + BCW'(1);
            end
          end else begin
            tick_cnt_d = tick_cnt_q + TCW'(1);
          end
        end

        ST_PARITY: begin
          if (centre_tick) begin
            tick_cnt_d = '0;
            bit_cnt_d  = '0;
            par_mis_d  = rx_s ^ parity_expected;
            state_d    = ST_STOP;
          end else begin
            tick_cnt_d = tick_cnt_q + TCW'(1);
          end
        end

        ST_STOP: begin
          if (centre_tick) begin
            tick_cnt_d = '0;
            if (bit_cnt_q == STOP_LAST) begin
              // Last stop sample: publish the frame and its error flags.
              bit_cnt_d    = '0;
              data_d       = NB_DATA'(shift_q);
              parity_err_d = par_mis_q;
              frame_err_d  = stop_low_now;
              rx_done_d    = 1'b1;
              stop_low_d   = stop_low_now;
              state_d      = stop_low_now ? ST_BREAK : ST_IDLE;
            end else begin
              bit_cnt_d  = bit_cnt_q + BCW'(1);
              stop_low_d = stop_low_now;
            end
          end else begin
            tick_cnt_d = tick_cnt_q + TCW'(1);
          end
        end

        ST_BREAK: begin
          // A line held low must return high before a new start is accepted.
          if (rx_s) begin
            state_d    = ST_IDLE;
            tick_cnt_d = '0;
          end
        end

        default: begin
          state_d    = ST_IDLE;
          tick_cnt_d = '0;
          bit_cnt_d  = '0;
        end
      endcase
    end
  end

  // State, counter, datapath and output registers with synchronous reset;
  // reset mid-frame simply abandons the frame.
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      state_q      <= ST_IDLE;
      tick_cnt_q   <= '0;
      bit_cnt_q    <= '0;
      shift_q      <= '0;
      par_mis_q    <= 1'b0;
      stop_low_q   <= 1'b0;
      data_q       <= '0;
      rx_done_q    <= 1'b0;
      parity_err_q <= 1'b0;
      frame_err_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      tick_cnt_q   <= tick_cnt_d;
      bit_cnt_q    <= bit_cnt_d;
      shift_q      <= shift_d;
      par_mis_q    <= par_mis_d;
      stop_low_q   <= stop_low_d;
      data_q       <= data_d;
      rx_done_q    <= rx_done_d;
      parity_err_q <= parity_err_d;
      frame_err_q  <= frame_err_d;
    end
  end

  assign o_data       = data_q;
  assign o_rx_done    = rx_done_q;
  assign o_parity_err = parity_err_q;
  assign o_frame_err  = frame_err_q;

endmodule
